cut_pattern_detector: RTL
=========================

Name: cut_pattern_detector

Overview:
Monitors a stereo audio stream and detects the periodic mute/unmute pattern produced by the cut-off/cut-on effect. It measures the length of each silent and sounding run in whole seconds and locks once the rhythm is stable. It then reports the matching 2-bit interval code. It sits downstream of the effect chain, on the same 32-bit left/right audio buses, and drives status LEDs/HEX and loop-sync logic.

Parameters:
CLK_HZ, 50000000, clock cycles per second; reduced in simulation.
SILENCE_THRESH, 0, a sample counts as silent when its magnitude (two's complement abs) is <= this value.
DEBOUNCE, 1024, consecutive cycles of the new condition required before a silent/sound phase change is accepted.

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
left_channel_audio_in  input  32  signed audio sample, evaluated every cycle.
right_channel_audio_in  input  32  signed audio sample, evaluated every cycle.
silent  output  1  debounced phase: 1 = in a silent run.
locked  output  1  stable cut rhythm detected.
detected_interval  output  2  interval code; valid when locked, else 0.
run_done  output  1  one-cycle pulse when a run completes.

Behaviour:
- Reset (async, active-high): FSM=IDLE; all counters 0; silent=0, locked=0, detected_interval=0, run_done=0.
- raw_silent = (|L| <= SILENCE_THRESH) AND (|R| <= SILENCE_THRESH).
  - abs of 32'h80000000 saturates to 32'h7FFFFFFF.
- Debounce: deb_cnt counts consecutive cycles where raw_silent != silent. A mismatch reset restarts it at 0. On reaching DEBOUNCE-1 the phase toggles on the next edge. Both directions are symmetric, so measured run lengths are unbiased.
- Run timing: sub_cnt counts 0..CLK_HZ-1. On wrap, sec_cnt (3-bit) increments, saturating at 7. Both counters clear on every phase toggle.
- Run length rounding: run_secs = sec_cnt + (sub_cnt >= CLK_HZ/2), saturating at 7.
- Run code: a run of (N+1) s maps to code N. Valid codes are 1..3, i.e. 2..4 s runs; any other length is invalid.
- FSM states:
  - IDLE: waits for the first debounced phase toggle. The run in progress at reset has unknown start, so it is discarded.
  - SOUND / SILENCE: the current phase. Each toggle ends the run: run_done pulses for 1 cycle, the run is classified, and the FSM enters the opposite state.
- Classification at run end:
  - Valid code equal to prev_code: match_cnt increments, saturating at 2.
  - Otherwise: match_cnt=0 and prev_code takes the new code; an invalid run stores 0.
- Lock:
  - locked=1 and detected_interval=prev_code when match_cnt reaches 2, i.e. three consecutive equal valid runs. Both update on the cycle after run_done.
  - A mismatch while locked clears locked and detected_interval the cycle after run_done.
- Timeout: sec_cnt reaching 5 in the current run clears locked, detected_interval and match_cnt immediately. Covers held silence or continuous music. FSM stays in its state.
- Simultaneous events: timeout and toggle on the same cycle → the toggle is processed as an invalid run.
- Reset mid-run: returns to IDLE; the next run is discarded.

Optional Feature:
CUT_DETECT_LOCK_PULSE_EN
- Defined: adds output lock_changed (1 bit). It pulses high for exactly one cycle whenever locked changes value, including lock loss by timeout. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Sim parameters for all scenarios: CLK_HZ=1000, DEBOUNCE=8, SILENCE_THRESH=0.
- Reset mid-stream: assert reset during sound → all outputs 0 within the same cycle; the first run after release produces run_done but no lock progress.
- Pattern with code 2: alternate sound (L=R=32'h00001000) and zeros every 3000 cycles → locked=1, detected_interval=2 on the cycle after the 4th run_done (first run discarded); stays locked.
- Glitch rejection: during a silent run, inject 5 cycles of L=1 → no run_done, silent stays 1, lock unaffected. Inject 8 cycles → phase toggles and lock drops on the next mismatch.
- Rhythm change: locked at code 1 (2000-cycle runs), switch to 4000-cycle runs → locked=0 after the first 4000-cycle run; relocks at detected_interval=3 after three 4000-cycle runs.
- Timeout and threshold:
  - Locked, then hold zeros for 6000 cycles → locked=0, interval=0 when sec_cnt hits 5.
  - With SILENCE_THRESH=16, samples of -16 count as silent; -17 does not.
  - Input 32'h80000000 is treated as non-silent.
- Optional macro: with CUT_DETECT_LOCK_PULSE_EN defined, lock_changed pulses exactly once at lock and once at loss in the scenarios above; never high for two consecutive cycles.

Source files
------------

// File: rtl/cut_pattern_detector.sv
// Cut-off/cut-on rhythm detector: debounces stereo silence, times each run
// in whole seconds and locks on three equal 2..4 s runs. Optional output
// lock_changed is enabled by defining CUT_DETECT_LOCK_PULSE_EN.
`timescale 1ns/1ps
module cut_pattern_detector #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned SILENCE_THRESH = 0,
    parameter int unsigned DEBOUNCE       = 1024
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        silent,
    output logic        locked,
    output logic [1:0]  detected_interval,
    output logic        run_done
`ifdef CUT_DETECT_LOCK_PULSE_EN
   ,output logic        lock_changed
`endif
);

    localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [SW-1:0] SUB_MAX  = SW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SUB_HALF = SW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE - 1);
    localparam logic [31:0]   THRESH   = 32'(SILENCE_THRESH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SOUND   = 2'd1,
        SILENCE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic          silent_q, silent_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [SW-1:0] sub_cnt_q, sub_cnt_d;
    logic [2:0]    sec_cnt_q, sec_cnt_d;
    logic [1:0]    prev_code_q, prev_code_d;
    logic [1:0]    match_cnt_q, match_cnt_d;
    logic          locked_q, locked_d;
    logic [1:0]    ival_q, ival_d;
    logic          run_done_q, run_done_d;

    logic          raw_silent;
    logic          mismatch;
    logic          toggle;
    logic          wrap;
    logic          timeout;
    logic          classify;
    logic [3:0]    secs_sum;
    logic [2:0]    run_secs;
    logic [2:0]    code_w;
    logic [1:0]    run_code;
    logic          code_valid;

    // Two's complement magnitude; the most negative value saturates
    function automatic logic [31:0] mag(input logic [31:0] x);
        if (!x[31]) begin
            return x;
        end else if (x == 32'h8000_0000) begin
            return 32'h7FFF_FFFF;
        end else begin
            return (~x) + 32'd1;
        end
    endfunction

    // Raw silence detection and symmetric debounce of the phase
    always_comb begin
        raw_silent = (mag(left_channel_audio_in) <= THRESH) &&
                     (mag(right_channel_audio_in) <= THRESH);
        mismatch   = raw_silent ^ silent_q;
        toggle     = mismatch && (deb_cnt_q == DEB_MAX);
        deb_cnt_d  = (!mismatch || toggle) ? '0 : deb_cnt_q + 1'b1;
        silent_d   = silent_q ^ toggle;
        run_done_d = toggle;
    end

    // Run timer in seconds, cleared whenever the phase changes
    always_comb begin
        wrap      = (sub_cnt_q == SUB_MAX);
        timeout   = wrap && (sec_cnt_q == 3'd4);
        sub_cnt_d = sub_cnt_q + 1'b1;
        sec_cnt_d = sec_cnt_q;
        if (toggle) begin
            sub_cnt_d = '0;
            sec_cnt_d = '0;
        end else if (wrap) begin
            sub_cnt_d = '0;
            if (sec_cnt_q != 3'd7) begin
                sec_cnt_d = sec_cnt_q + 3'd1;
            end
        end
    end

    // Rounded run length and its interval code
    always_comb begin
        secs_sum   = {1'b0, sec_cnt_q} + {3'b000, (sub_cnt_q >= SUB_HALF)};
        run_secs   = secs_sum[3] ? 3'd7 : secs_sum[2:0];
        code_w     = run_secs - 3'd1;
        run_code   = code_w[1:0];
        code_valid = (run_secs >= 3'd2) && (run_secs <= 3'd4) && !timeout;
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: each accepted toggle enters the opposite phase
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (toggle) state_d = silent_d ? SILENCE : SOUND;
            SOUND:   if (toggle) state_d = SILENCE;
            SILENCE: if (toggle) state_d = SOUND;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: only runs with a known start are classified
    always_comb begin
        classify = 1'b0;
        unique case (state_q)
            SOUND, SILENCE: classify = toggle;
            default:        classify = 1'b0;
        endcase
    end

    // Run classification and match counting
    always_comb begin
        prev_code_d = prev_code_q;
        match_cnt_d = match_cnt_q;
        if (timeout) begin
            match_cnt_d = 2'd0;
        end
        if (classify) begin
            if (code_valid && (run_code == prev_code_q)) begin
                match_cnt_d = (match_cnt_q == 2'd2) ? 2'd2 : match_cnt_q + 2'd1;
            end else begin
                match_cnt_d = 2'd0;
                prev_code_d = code_valid ? run_code : 2'd0;
            end
        end
    end

    // Lock decision one cycle after a run ends; timeout overrides
    always_comb begin
        locked_d = locked_q;
        ival_d   = ival_q;
        if (run_done_q) begin
            locked_d = (match_cnt_q == 2'd2);
            ival_d   = (match_cnt_q == 2'd2) ? prev_code_q : 2'd0;
        end
        if (timeout) begin
            locked_d = 1'b0;
            ival_d   = 2'd0;
        end
    end

    // Datapath state
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            silent_q    <= 1'b0;
            deb_cnt_q   <= '0;
            sub_cnt_q   <= '0;
            sec_cnt_q   <= '0;
            prev_code_q <= 2'd0;
            match_cnt_q <= 2'd0;
            locked_q    <= 1'b0;
            ival_q      <= 2'd0;
            run_done_q  <= 1'b0;
        end else begin
            silent_q    <= silent_d;
            deb_cnt_q   <= deb_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            prev_code_q <= prev_code_d;
            match_cnt_q <= match_cnt_d;
            locked_q    <= locked_d;
            ival_q      <= ival_d;
            run_done_q  <= run_done_d;
        end
    end

`ifdef CUT_DETECT_LOCK_PULSE_EN
    logic lock_chg_q;

    // Pulse aligned with the cycle in which locked shows its new value
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lock_chg_q <= 1'b0;
        end else begin
            lock_chg_q <= (locked_d != locked_q);
        end
    end

    assign lock_changed = lock_chg_q;
`endif

    assign silent            = silent_q;
    assign locked            = locked_q;
    assign detected_interval = ival_q;
    assign run_done          = run_done_q;

endmodule
